// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - multi-channel button debouncer with press/release pulses
// Optional hold detection: define MULTI_DEBOUNCE_LONG_PRESS_EN to enable long_pulse.
module multi_debounce #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int ACTIVE_LOW      = 0,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_pressed,
    output logic [CHANNELS-1:0] long_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic INACTIVE = (ACTIVE_LOW != 0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          state;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic [CW-1:0] cnt;
        logic          s;
        logic          accept;

        assign s      = sync2 ^ INACTIVE;
        assign accept = (s != state) && (cnt == CNT_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1     <= INACTIVE;
                sync2     <= INACTIVE;
                state     <= 1'b0;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1     <= button_in[i];
                sync2     <= sync1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (s == state) begin
                    cnt <= '0;
                end else if (accept) begin
                    state     <= s;
                    cnt       <= '0;
                    press_q   <= s;
                    release_q <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
        localparam int LW = $clog2(LONG_CYCLES + 1);
        localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES);
        logic [LW-1:0] hold;

        // Saturating at HOLD_MAX is what limits the pulse to once per press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold   <= '0;
                long_q <= 1'b0;
            end else if (!state || (accept && !s)) begin
                hold   <= '0;
                long_q <= 1'b0;
            end else if (hold != HOLD_MAX) begin
                hold   <= hold + 1'b1;
                long_q <= (hold == HOLD_MAX - 1'b1);
            end else begin
                long_q <= 1'b0;
            end
        end
`else
        assign long_q = 1'b0;
`endif

        assign button_out[i]    = state;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |button_out;
        end
    end

endmodule
